// File: rtl/alu_16_muldiv_seq.sv
// Sequencer that runs unsigned 16-bit multiply (shift-add) and divide (restoring)
// one step per clock on the shared add/sub ALU. The ALU is driven and read combinationally.
module alu_16_muldiv_seq #(
    parameter logic [4:0] OP_ADD = 5'b00000,
    parameter logic [4:0] OP_SUB = 5'b00001,
    parameter int         N_ITER = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        op_div,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic        busy,
    output logic        result_valid,
    output logic [15:0] result,
    output logic [15:0] remainder,
    output logic        exception,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [4:0]  alu_opcode,
    input  logic [15:0] alu_result,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    localparam logic [3:0] LAST_CNT = 4'(N_ITER - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [15:0] acc;     // P for multiply, R for divide
    logic [15:0] sh;      // Q: multiplier (shifts right) or dividend/quotient (shifts left)
    logic [15:0] opd;     // M (shifts left) for multiply, D for divide
    logic        ovf;
    logic        is_div;

    logic [15:0] t_word;
    logic [15:0] sh_right;
    logic        carry_add;
    logic        carry_sub;
    logic        no_borrow;

    // Carry-out of the ALU is rebuilt from operand and result MSBs.
    assign t_word    = {acc[14:0], sh[15]};
    assign sh_right  = sh >> 1;
    assign carry_add = (acc[15] & opd[15]) | (~alu_result[15] & (acc[15] | opd[15]));
    assign carry_sub = (t_word[15] & ~opd[15]) | (~alu_result[15] & (t_word[15] | ~opd[15]));
    assign no_borrow = acc[15] | carry_sub;

    always_comb begin
        alu_a      = 16'd0;
        alu_b      = 16'd0;
        alu_opcode = OP_ADD;
        case (state)
            S_MUL: begin
                alu_a      = acc;
                alu_b      = opd;
                alu_opcode = OP_ADD;
            end
            S_DIV: begin
                alu_a      = t_word;
                alu_b      = opd;
                alu_opcode = OP_SUB;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            cnt    <= 4'd0;
            acc    <= 16'd0;
            sh     <= 16'd0;
            opd    <= 16'd0;
            ovf    <= 1'b0;
            is_div <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc    <= 16'd0;
                        sh     <= op_div ? op_a : op_b;
                        opd    <= op_div ? op_b : op_a;
                        ovf    <= 1'b0;
                        is_div <= op_div;
                        cnt    <= 4'd0;
                        state  <= op_div ? S_DIV : S_MUL;
                    end
                end
                S_MUL: begin
                    if (sh[0]) begin
                        acc <= alu_result;
                        if (carry_add) ovf <= 1'b1;
                    end
                    // A multiplicand bit falls off the top while multiplier bits remain.
                    if (opd[15] && (sh_right != 16'd0)) ovf <= 1'b1;
                    opd <= opd << 1;
                    sh  <= sh_right;
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST_CNT) state <= S_DONE;
                end
                S_DIV: begin
                    if (no_borrow) begin
                        acc <= alu_result;
                        sh  <= {sh[14:0], 1'b1};
                    end else begin
                        acc <= t_word;
                        sh  <= {sh[14:0], 1'b0};
                    end
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST_CNT) state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Results come straight from the datapath registers, which only change on accept.
    assign busy         = (state != S_IDLE);
    assign result_valid = (state == S_DONE);
    assign result       = is_div ? sh : acc;
    assign remainder    = is_div ? acc : 16'd0;
    assign exception    = is_div ? (opd == 16'd0) : ovf;
    assign dbg_state    = state;

endmodule

// File: tb/tb_alu_16_muldiv_seq.sv
// Bench for alu_16_muldiv_seq: models the add/sub ALU, drives vector tables and
// corner sequences, scoreboards {result, remainder, exception} per operation.
module tb_alu_16_muldiv_seq;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        op_div = 1'b0;
    logic [15:0] op_a = 16'd0;
    logic [15:0] op_b = 16'd0;
    logic        busy;
    logic        result_valid;
    logic [15:0] result;
    logic [15:0] remainder;
    logic        exception;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [4:0]  alu_opcode;
    logic [15:0] alu_result;
    logic [1:0]  dbg_state;

    int n_pass = 0;
    int n_total = 0;
    logic [32:0] exp_q[$];

    typedef struct {
        logic        div;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [15:0] rem;
        logic        exc;
    } vec_t;

    vec_t vecs[10];

    alu_16_muldiv_seq dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .op_div       (op_div),
        .op_a         (op_a),
        .op_b         (op_b),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result),
        .remainder    (remainder),
        .exception    (exception),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_opcode   (alu_opcode),
        .alu_result   (alu_result),
        .dbg_state    (dbg_state)
    );

    // Shared ALU model: add or subtract, modulo 2^16.
    assign alu_result = (alu_opcode == 5'b00001) ? (alu_a - alu_b) : (alu_a + alu_b);

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [47:0] got, input logic [47:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, want);
    endtask

    function automatic logic [32:0] model(input logic div, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] prod;
        if (div) begin
            if (b == 16'd0) return {16'hFFFF, a, 1'b1};
            return {a / b, a % b, 1'b0};
        end
        prod = 32'(a) * 32'(b);
        return {prod[15:0], 16'd0, (prod[31:16] != 16'd0)};
    endfunction

    // One operation; with glitch set, extra start pulses land in cycle 5 and in DONE.
    task automatic run_op(input logic div, input logic [15:0] a, input logic [15:0] b,
                          input logic [32:0] want, input bit glitch);
        int          cyc;
        bit          bad_busy;
        bit          bad_op;
        logic [32:0] e;
        logic [4:0]  want_op;
        want_op  = div ? 5'b00001 : 5'b00000;
        bad_busy = 0;
        bad_op   = 0;
        @(negedge clock);
        op_div = div; op_a = a; op_b = b; start = 1'b1;
        exp_q.push_back(want);
        @(negedge clock);
        start = 1'b0;
        cyc = 1;
        while (!result_valid && cyc < 40) begin
            if (!busy) bad_busy = 1;
            if (alu_opcode !== want_op) bad_op = 1;
            if (glitch && cyc == 5) begin
                start = 1'b1; op_a = ~a; op_b = 16'h0003; op_div = ~div;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            cyc++;
        end
        check("latency", 48'(cyc), 48'd17);
        check("busy_during_op", {47'd0, bad_busy}, 48'd0);
        check("alu_opcode_iter", {47'd0, bad_op}, 48'd0);
        check("busy_in_done", {47'd0, busy}, 48'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 33'd0;
        check("result", {32'd0, result}, {32'd0, e[32:17]});
        check("remainder", {32'd0, remainder}, {32'd0, e[16:1]});
        check("exception", {47'd0, exception}, {47'd0, e[0]});
        if (glitch) start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("single_pulse", {46'd0, result_valid, busy}, 48'd0);
        if (glitch) begin
            repeat (3) @(negedge clock);
            check("ignored_start_idle", {46'd0, busy, result_valid}, 48'd0);
            check("hold", {15'd0, result, remainder, exception}, {15'd0, e});
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 16'h0003, 16'h0005, 16'h000F, 16'h0000, 1'b0};
        vecs[1] = '{1'b0, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 1'b1};
        vecs[2] = '{1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0};
        vecs[3] = '{1'b1, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0};
        vecs[4] = '{1'b1, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0};
        vecs[5] = '{1'b1, 16'h8000, 16'h8001, 16'h0000, 16'h8000, 1'b0};
        vecs[6] = '{1'b1, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1};
        vecs[7] = '{1'b0, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 1'b0};
        vecs[8] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
        vecs[9] = '{1'b1, 16'h0007, 16'h0064, 16'h0000, 16'h0007, 1'b0};

        // Clock/reset
        repeat (3) @(negedge clock);
        check("reset_outputs", {busy, result_valid, result, remainder, exception, alu_opcode, 8'd0},
              48'd0);
        check("reset_alu_ops", {16'd0, alu_a, alu_b}, 48'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check("idle_state", {46'd0, dbg_state}, 48'd0);

        // Vector table
        for (int i = 0; i < 10; i++)
            run_op(vecs[i].div, vecs[i].a, vecs[i].b, {vecs[i].res, vecs[i].rem, vecs[i].exc}, 0);

        // Ignored start pulses during the operation and in DONE
        run_op(1'b0, 16'h0003, 16'h0005, {16'h000F, 16'h0000, 1'b0}, 1);
        run_op(1'b1, 16'h0064, 16'h0007, {16'h000E, 16'h0002, 1'b0}, 1);

        // Asynchronous reset at iteration 7
        @(negedge clock);
        op_div = 1'b0; op_a = 16'h1234; op_b = 16'h0077; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (6) @(negedge clock);
        check("busy_before_reset", {47'd0, busy}, 48'd1);
        reset_n = 1'b0;
        #1;
        check("midop_reset_flags", {44'd0, busy, result_valid, exception, 1'b0}, 48'd0);
        check("midop_reset_data", {16'd0, result, remainder}, 48'd0);
        check("midop_reset_alu", {11'd0, alu_a, alu_b, alu_opcode}, 48'd0);
        @(negedge clock);
        reset_n = 1'b1;
        run_op(1'b0, 16'h1234, 16'h0007, model(1'b0, 16'h1234, 16'h0007), 0);

        // Random operands against the arithmetic model
        for (int i = 0; i < 12; i++) begin
            logic        d;
            logic [15:0] a;
            logic [15:0] b;
            d = 1'($urandom_range(0, 1));
            a = 16'($urandom_range(0, 65535));
            b = (i % 4 == 3) ? 16'd0 : 16'($urandom_range(0, (i % 2) ? 65535 : 255));
            run_op(d, a, b, model(d, a, b), 0);
        end

        @(negedge clock);
        check("idle_alu_opcode", {43'd0, alu_opcode}, 48'd0);
        check("queue_empty", 48'(exp_q.size()), 48'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
